// File: rtl/ctrl_sequencer_if.sv
// Control bundle between the fetch/decode/execute/writeback sequencer and the
// 16-bit datapath: instruction fetch, register-file strobes, ALU and immediate controls.
interface ctrl_sequencer_if #(
    parameter int PC_W = 8
);
    logic [15:0]     instr;
    logic            instr_valid;
    logic            alu_zero;
    logic [PC_W-1:0] pc;
    logic [2:0]      readreg1;
    logic [2:0]      readreg2;
    logic [2:0]      writereg;
    logic            en;
    logic            regen;
    logic [3:0]      alu_op;
    logic [15:0]     imm;
    logic            imm_sel;
    logic            halted;
    logic            illegal;

    modport master (
        input  instr, instr_valid, alu_zero,
        output pc, readreg1, readreg2, writereg, en, regen,
               alu_op, imm, imm_sel, halted, illegal
    );

    modport slave (
        output instr, instr_valid, alu_zero,
        input  pc, readreg1, readreg2, writereg, en, regen,
               alu_op, imm, imm_sel, halted, illegal
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// Four-phase FETCH/DECODE/EXECUTE/WRITEBACK controller for the 8-register RISC datapath.
// Owns the PC, branches and HALT; all outputs decode from state, ir and pc only.
module ctrl_sequencer #(
    parameter int PC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    ctrl_sequencer_if.master   bus
);

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_HALT
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_BEQZ = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t          state_q, state_d;
    logic [15:0]     ir_q, ir_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            taken_q, taken_d;

    logic [3:0]      op;
    logic [2:0]      rd, rs1, rs2;
    logic            is_alu, is_ldi, is_beqz, is_jmp, is_halt, is_illegal, writes_rd;
    logic [PC_W-1:0] br_off;
    logic [PC_W-1:0] pc_inc;
    logic [15:0]     imm_ext;

    logic [2:0]      readreg1_out, readreg2_out, writereg_out;
    logic            en_out, regen_out, imm_sel_out, halted_out, illegal_out;
    logic [3:0]      alu_op_out;
    logic [15:0]     imm_out;

    assign op  = ir_q[15:12];
    assign rd  = ir_q[11:9];
    assign rs1 = ir_q[8:6];
    assign rs2 = ir_q[5:3];

    assign is_alu     = (op >= 4'h1) && (op <= 4'h7);
    assign is_ldi     = (op == OP_LDI);
    assign is_beqz    = (op == OP_BEQZ);
    assign is_jmp     = (op == OP_JMP);
    assign is_halt    = (op == OP_HALT);
    assign is_illegal = (op >= 4'hB) && (op <= 4'hE);
    assign writes_rd  = is_alu || is_ldi;

    assign imm_ext = {{7{ir_q[8]}}, ir_q[8:0]};
    assign pc_inc  = pc_q + PC_W'(1);

    // Branch offset is a signed 6-bit field; PC arithmetic simply wraps at 2^PC_W.
    always_comb begin
        br_off      = {PC_W{ir_q[5]}};
        br_off[5:0] = ir_q[5:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
            pc_q    <= '0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FETCH:     if (bus.instr_valid) state_d = ST_DECODE;
            ST_DECODE:    state_d = is_halt ? ST_HALT : ST_EXECUTE;
            ST_EXECUTE:   state_d = ST_WRITEBACK;
            ST_WRITEBACK: state_d = ST_FETCH;
            ST_HALT:      state_d = ST_HALT;
            default:      state_d = ST_FETCH;
        endcase
    end

    // alu_zero is only meaningful at the end of EXECUTE, so it is latched there and
    // consumed by the PC update at the end of WRITEBACK.
    always_comb begin
        ir_d    = ir_q;
        pc_d    = pc_q;
        taken_d = taken_q;
        if (state_q == ST_FETCH && bus.instr_valid) begin
            ir_d    = bus.instr;
            taken_d = 1'b0;
        end
        if (state_q == ST_EXECUTE && is_beqz) begin
            taken_d = bus.alu_zero;
        end
        if (state_q == ST_WRITEBACK) begin
            if (is_jmp) begin
                pc_d = ir_q[PC_W-1:0];
            end else if (is_beqz && taken_q) begin
                pc_d = pc_inc + br_off;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_comb begin
        readreg1_out = 3'd0;
        readreg2_out = 3'd0;
        writereg_out = 3'd0;
        en_out       = 1'b0;
        regen_out    = 1'b0;
        alu_op_out   = 4'd0;
        imm_out      = 16'd0;
        imm_sel_out  = 1'b0;
        halted_out   = 1'b0;
        illegal_out  = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
            end
            ST_DECODE: begin
                readreg1_out = rs1;
                readreg2_out = rs2;
                en_out       = 1'b1;
                illegal_out  = is_illegal;
            end
            ST_EXECUTE: begin
                readreg1_out = rs1;
                readreg2_out = rs2;
                alu_op_out   = is_alu ? op : 4'd0;
                imm_out      = is_ldi ? imm_ext : 16'd0;
                imm_sel_out  = is_ldi;
            end
            ST_WRITEBACK: begin
                readreg1_out = rs1;
                readreg2_out = rs2;
                writereg_out = rd;
                alu_op_out   = is_alu ? op : 4'd0;
                imm_out      = is_ldi ? imm_ext : 16'd0;
                imm_sel_out  = is_ldi;
                en_out       = writes_rd;
                regen_out    = writes_rd;
            end
            ST_HALT: begin
                halted_out = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.pc       = pc_q;
    assign bus.readreg1 = readreg1_out;
    assign bus.readreg2 = readreg2_out;
    assign bus.writereg = writereg_out;
    assign bus.en       = en_out;
    assign bus.regen    = regen_out;
    assign bus.alu_op   = alu_op_out;
    assign bus.imm      = imm_out;
    assign bus.imm_sel  = imm_sel_out;
    assign bus.halted   = halted_out;
    assign bus.illegal  = illegal_out;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: reset corners, a directed vector table,
// randomized instructions against an instruction-level model, and HALT behaviour.
module tb_ctrl_sequencer;

    localparam int PC_W  = 8;
    localparam int DEPTH = 1 << PC_W;

    logic clk = 1'b0;
    logic rst;

    ctrl_sequencer_if #(.PC_W(PC_W)) bus();

    ctrl_sequencer #(.PC_W(PC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PC_W-1:0] pc_after;
        int              regen_cnt;
        logic [2:0]      writereg;
        logic [15:0]     imm;
        logic            imm_sel;
        logic [3:0]      alu_op;
        bit              chk_alu;
        int              en_cnt;
        logic [2:0]      rd1;
        logic [2:0]      rd2;
        int              ill_cnt;
        int              hold_err;
        int              strobe_err;
    } exp_t;

    typedef struct {
        logic [15:0] ins;
        int          stall;
        bit          z;
        exp_t        e;
    } vec_t;

    int    total = 0;
    int    bad   = 0;
    int    model_pc;
    int    halt_err;
    exp_t  obs;
    exp_t  expv;
    vec_t  vecs[15];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outVec();
        return {22'd0, bus.pc, bus.readreg1, bus.readreg2, bus.writereg, bus.en, bus.regen,
                bus.alu_op, bus.imm, bus.imm_sel, bus.halted, bus.illegal};
    endfunction

    function automatic vec_t mkVec(logic [15:0] ins, int stall, bit z, int pc, int wr, int imm,
                                   bit isel, int alu, bit chk, int rd1, int rd2, int ill, bit wrt);
        vec_t v;
        v.ins   = ins;
        v.stall = stall;
        v.z     = z;
        v.e     = '{default: 0};
        v.e.pc_after  = PC_W'(pc);
        v.e.regen_cnt = wrt ? 1 : 0;
        v.e.en_cnt    = wrt ? 2 : 1;
        v.e.writereg  = 3'(wr);
        v.e.imm       = 16'(imm);
        v.e.imm_sel   = isel;
        v.e.alu_op    = 4'(alu);
        v.e.chk_alu   = chk;
        v.e.rd1       = 3'(rd1);
        v.e.rd2       = 3'(rd2);
        v.e.ill_cnt   = ill;
        return v;
    endfunction

    // Instruction-level reference: what one instruction should do to the PC and the register file.
    function automatic exp_t modelInstr(int pc, logic [15:0] ins, bit z);
        exp_t        e;
        int          op;
        int          nxt;
        int          v;
        logic [8:0]  f9;
        logic [5:0]  f6;
        e   = '{default: 0};
        op  = int'(ins[15:12]);
        nxt = (pc + 1) % DEPTH;
        e.en_cnt = 1;
        e.rd1    = ins[8:6];
        e.rd2    = ins[5:3];
        if (op >= 1 && op <= 7) begin
            e.regen_cnt = 1;
            e.alu_op    = 4'(op);
            e.chk_alu   = 1'b1;
        end else if (op == 8) begin
            f9 = ins[8:0];
            v  = int'(f9);
            if (v >= 256) v -= 512;
            e.regen_cnt = 1;
            e.imm_sel   = 1'b1;
            e.imm       = 16'(v);
        end else if (op == 9) begin
            if (z) begin
                f6 = ins[5:0];
                v  = int'(f6);
                if (v >= 32) v -= 64;
                nxt = (((pc + 1 + v) % DEPTH) + DEPTH) % DEPTH;
            end
        end else if (op == 10) begin
            nxt = int'(ins) % DEPTH;
        end else if (op >= 11 && op <= 14) begin
            e.ill_cnt = 1;
        end
        if (e.regen_cnt == 1) begin
            e.en_cnt   = 2;
            e.writereg = ins[11:9];
        end
        e.pc_after = PC_W'(nxt);
        return e;
    endfunction

    // Runs one whole instruction from FETCH entry, with `stall` invalid fetch cycles first.
    task automatic applyStimulus(input logic [15:0] ins, input int stall, input bit z, output exp_t o);
        bit first_en;
        o = '{default: 0};
        first_en = 1'b1;
        bus.instr    = ins;
        bus.alu_zero = z;
        for (int c = 0; c < stall + 4; c++) begin
            bus.instr_valid = (c >= stall);
            @(negedge clk);
            if (c < stall && (bus.pc !== PC_W'(model_pc) || bus.en !== 1'b0)) o.hold_err++;
            if (bus.regen === 1'b1) begin
                o.regen_cnt++;
                o.writereg = bus.writereg;
                o.imm      = bus.imm;
                o.imm_sel  = bus.imm_sel;
                o.alu_op   = bus.alu_op;
                if (bus.en !== 1'b1) o.strobe_err++;
            end
            if (bus.en === 1'b1) begin
                o.en_cnt++;
                if (first_en) begin
                    o.rd1    = bus.readreg1;
                    o.rd2    = bus.readreg2;
                    first_en = 1'b0;
                end
            end
            if (bus.illegal === 1'b1) o.ill_cnt++;
            @(posedge clk);
            #1;
        end
        bus.instr_valid = 1'b0;
        o.pc_after = bus.pc;
    endtask

    task automatic checkInstr(input string tag, input exp_t o, input exp_t e);
        checkOutput({tag, " pc"},        o.pc_after,  e.pc_after);
        checkOutput({tag, " regen_cnt"}, o.regen_cnt, e.regen_cnt);
        checkOutput({tag, " en_cnt"},    o.en_cnt,    e.en_cnt);
        checkOutput({tag, " readreg1"},  o.rd1,       e.rd1);
        checkOutput({tag, " readreg2"},  o.rd2,       e.rd2);
        checkOutput({tag, " illegal"},   o.ill_cnt,   e.ill_cnt);
        checkOutput({tag, " stall"},     o.hold_err,  0);
        checkOutput({tag, " strobe"},    o.strobe_err, 0);
        if (e.regen_cnt == 1) begin
            checkOutput({tag, " writereg"}, o.writereg, e.writereg);
            checkOutput({tag, " imm_sel"},  o.imm_sel,  e.imm_sel);
            if (e.imm_sel) checkOutput({tag, " imm"}, o.imm, e.imm);
            if (e.chk_alu) checkOutput({tag, " alu_op"}, o.alu_op, e.alu_op);
        end
    endtask

    initial begin
        //                 ins       st z  pc   wr imm     isel alu chk rd1 rd2 ill wrt
        vecs[0]  = mkVec(16'h8200, 0, 0, 1,   1, 16'h0000, 1, 0, 0, 0, 0, 0, 1);
        vecs[1]  = mkVec(16'h8401, 0, 0, 2,   2, 16'h0001, 1, 0, 0, 0, 0, 0, 1);
        vecs[2]  = mkVec(16'h1650, 0, 0, 3,   3, 0,        0, 1, 1, 1, 2, 0, 1);
        vecs[3]  = mkVec(16'h2CD8, 0, 0, 4,   6, 0,        0, 2, 1, 3, 3, 0, 1);
        vecs[4]  = mkVec(16'hA005, 0, 0, 5,   0, 0,        0, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mkVec(16'h903E, 0, 1, 4,   0, 0,        0, 0, 0, 0, 7, 0, 0);
        vecs[6]  = mkVec(16'hA005, 0, 0, 5,   0, 0,        0, 0, 0, 0, 0, 0, 0);
        vecs[7]  = mkVec(16'h903E, 0, 0, 6,   0, 0,        0, 0, 0, 0, 7, 0, 0);
        vecs[8]  = mkVec(16'hC000, 0, 0, 7,   0, 0,        0, 0, 0, 0, 0, 1, 0);
        vecs[9]  = mkVec(16'hA0FF, 0, 0, 255, 0, 0,        0, 0, 0, 3, 7, 0, 0);
        vecs[10] = mkVec(16'h0000, 0, 0, 0,   0, 0,        0, 0, 0, 0, 0, 0, 0);
        vecs[11] = mkVec(16'hA000, 0, 0, 0,   0, 0,        0, 0, 0, 0, 0, 0, 0);
        vecs[12] = mkVec(16'h903F, 0, 1, 0,   0, 0,        0, 0, 0, 0, 7, 0, 0);
        vecs[13] = mkVec(16'h0000, 3, 0, 1,   0, 0,        0, 0, 0, 0, 0, 0, 0);
        vecs[14] = mkVec(16'h81FF, 0, 0, 2,   0, 16'hFFFF, 1, 0, 0, 7, 7, 0, 1);

        rst             = 1'b1;
        bus.instr       = 16'h0000;
        bus.instr_valid = 1'b0;
        bus.alu_zero    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs", outVec(), 64'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset landing in the middle of EXECUTE must clear every output at once.
        bus.instr       = 16'h1650;
        bus.instr_valid = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkOutput("execute_before_reset", {bus.readreg1, bus.alu_op}, {3'd1, 4'd1});
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_execute", outVec(), 64'd0);
        bus.instr_valid = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        bus.instr       = 16'h8401;
        bus.instr_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("writeback_before_reset", {bus.regen, bus.writereg}, {1'b1, 3'd2});
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_writeback", outVec(), 64'd0);
        bus.instr_valid = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        model_pc = 0;

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].ins, vecs[i].stall, vecs[i].z, obs);
            checkInstr($sformatf("vec%0d", i), obs, vecs[i].e);
            model_pc = int'(vecs[i].e.pc_after);
        end

        for (int n = 0; n < 80; n++) begin
            logic [3:0]  op4;
            logic [15:0] ins;
            int          st;
            bit          z;
            op4  = 4'($urandom_range(0, 14));
            ins  = {op4, 12'($urandom)};
            st   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            z    = 1'($urandom_range(0, 1));
            expv = modelInstr(model_pc, ins, z);
            applyStimulus(ins, st, z, obs);
            checkInstr($sformatf("rand%0d op%0h", n, op4), obs, expv);
            model_pc = int'(expv.pc_after);
        end

        bus.instr       = 16'hF000;
        bus.instr_valid = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkOutput("halt_entry", {bus.halted, bus.pc}, {1'b1, PC_W'(model_pc)});
        halt_err = 0;
        for (int c = 0; c < 20; c++) begin
            bus.instr       = 16'($urandom);
            bus.instr_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.halted !== 1'b1 || bus.pc !== PC_W'(model_pc) ||
                bus.en !== 1'b0 || bus.regen !== 1'b0) halt_err++;
            @(posedge clk);
            #1;
        end
        checkOutput("halt_hold", halt_err, 0);
        rst = 1'b1;
        #1;
        checkOutput("halt_reset", outVec(), 64'd0);
        bus.instr_valid = 1'b0;
        @(negedge clk) rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
